pix_proc_pipe: RTL and testbench
================================

// Module: pix_proc_pipe
// PURPOSE
//  Parametrised pixel-processing stage between ZBT read-back and ZBT bank-1 write.
//  Takes packed multi-pixel words with a valid strobe; applies a runtime-selected op
//  (pass / quantise-mask / binary threshold / masked highlight) in a 2-stage pipeline.
//  Emits the write address through a configurable delay line and keeps a per-frame
//  count of threshold-hit pixels.
// PARAMETERS
//  PIX_PER_WORD  2    pixels packed per data word
//  CH_BITS       6    bits per colour channel; pixel = {R,G,B}, PIX_W = 3*CH_BITS
//  ADDR_W        19   ZBT word-address width
//  ADDR_SKEW     0    extra address delay beyond data latency, cycles (0..1023)
//  CNT_W         20   hit-counter width
// PORTS
//  clk             in   1                   pixel clock
//  reset           in   1                   asynchronous, active-low
//  in_valid        in   1                   in_data/in_addr valid this cycle
//  in_data         in   PIX_PER_WORD*PIX_W  pixel 0 in MSBs; per pixel R MSB, then G, B
//  in_addr         in   ADDR_W              write address for in_data
//  mode            in   2                   0 PASS, 1 MASK, 2 THRESH, 3 HILITE
//  keep_r/g/b      in   3 each              MSBs kept per channel (>CH_BITS clamps to CH_BITS)
//  thr_r/g/b       in   CH_BITS each        per-channel threshold (>=)
//  frame_start     in   1                   one-cycle pulse at frame boundary
//  out_valid       out  1                   out_data valid
//  out_data        out  PIX_PER_WORD*PIX_W  processed word
//  out_addr_valid  out  1                   out_addr valid
//  out_addr        out  ADDR_W              delayed write address
//  hit_count       out  CNT_W               hits in current frame (saturating)
//  hit_count_last  out  CNT_W               final hit_count of previous frame
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0; pipeline and delay-line valid/addr bits 0.
//  - mode/keep/thr are captured with each in_valid beat into stage 1 and travel with
//    the beat; a mid-stream change affects only beats accepted after the change.
//  - Stage 1 (cycle N+1 after beat at N): per channel masked = ch with its low
//    (CH_BITS-keep) bits cleared; keep=0 -> 0; hit = R>=thr_r & G>=thr_g & B>=thr_b
//    on RAW channels. Captured raw, masked, hit, mode registered.
//  - Stage 2 (cycle N+2): per pixel PASS->raw; MASK->masked; THRESH->all-ones if hit
//    else 0; HILITE->masked if hit else 0. out_valid=1 exactly at N+2, one cycle.
//  - Bubbles: no in_valid -> out_valid 0 two cycles later; out_data holds last value.
//  - Address: out_addr/out_addr_valid = in_addr/in_valid delayed 2+ADDR_SKEW cycles;
//    with ADDR_SKEW=0 address and data are aligned; nonzero skew is deliberate
//    misalignment for write-timing experiments, no compensation applied.
//  - Hit count: at each out_valid, add number of hit pixels in that word (0..PIX_PER_WORD),
//    in every mode; saturate at 2^CNT_W-1, never wrap.
//  - frame_start: hit_count_last <= hit_count (value before this cycle's add);
//    hit_count <= hits of any out_valid word that same cycle (else 0).
//  - Async reset mid-frame: in-flight beats dropped; no out_valid until new beats
//    arrive and traverse the full latency.
//  - No backpressure: downstream must accept every out_valid beat.
// STRUCTURE
//  - Shared package pix_pkg: mode encodings (PIX_MODE_PASS/MASK/THRESH/HILITE), CH_BITS
//    default, pixel field-extract/pack helpers (functions).
//  - Sub-module addr_delay_line #(WIDTH=ADDR_W+1, DEPTH): shift-register delay of
//    {valid,addr}; DEPTH=2+ADDR_SKEW; async active-low reset clears all taps.
//  - Per-pixel datapath is a generate loop over PIX_PER_WORD; counter in top level.
// TESTING
//  - Defaults, mode=PASS, beat 36'h3F_F00_0AB at addr 5 -> N+2 out_data identical,
//    out_addr 5, both valids high same cycle.
//  - mode=MASK keep_r=2,keep_g=3,keep_b=2, all-ones word -> 36'h{30,38,30,30,38,30} packed.
//  - mode=THRESH thr=32/32/32, pixel0 {40,40,40}, pixel1 {40,10,40} -> pixel0 all-ones,
//    pixel1 0; hit_count +1.
//  - ADDR_SKEW=150: addr 7 at N -> out_valid at N+2, out_addr_valid/7 at N+152.
//  - CNT_W=4, stream 10 two-hit words -> hit_count sticks at 15; frame_start
//    -> hit_count_last=15, hit_count=0 (or hits of coincident word).
//  - reset low mid-stream with 2 beats in flight -> outputs 0 at once, no out_valid after release.

Source files
------------

// File: rtl/pix_pkg.sv
// Shared definitions for the pixel-processing pipe: op encodings and pixel
// field helpers sized for the widest supported channel (16 bits).
package pix_pkg;

  typedef enum logic [1:0] {
    PIX_MODE_PASS   = 2'd0,
    PIX_MODE_MASK   = 2'd1,
    PIX_MODE_THRESH = 2'd2,
    PIX_MODE_HILITE = 2'd3
  } pix_mode_e;

  localparam int PIX_CH_BITS_DEF = 6;
  localparam int PIX_CH_MAX      = 16;
  localparam int PIX_MAX_W       = 3 * PIX_CH_MAX;

  typedef logic [PIX_CH_MAX-1:0] pix_ch_t;
  typedef logic [PIX_MAX_W-1:0]  pix_max_t;

  function automatic pix_ch_t ch_ones(input int ch_bits);
    return pix_ch_t'((1 << ch_bits) - 1);
  endfunction

  // idx 0 = R (most significant), 1 = G, 2 = B
  function automatic pix_ch_t chan_get(input pix_max_t pix, input int ch_bits, input int idx);
    pix_max_t sh;
    sh = pix >> ((2 - idx) * ch_bits);
    return sh[PIX_CH_MAX-1:0] & ch_ones(ch_bits);
  endfunction

  function automatic pix_max_t pix_pack(input pix_ch_t r, input pix_ch_t g, input pix_ch_t b,
                                        input int ch_bits);
    return (pix_max_t'(r) << (2 * ch_bits)) | (pix_max_t'(g) << ch_bits) | pix_max_t'(b);
  endfunction

  // Keeps the top 'keep' bits of a channel; keep beyond the channel width clamps.
  function automatic pix_ch_t keep_mask(input logic [2:0] keep, input int ch_bits);
    int k;
    k = (int'(keep) > ch_bits) ? ch_bits : int'(keep);
    return pix_ch_t'(((1 << k) - 1) << (ch_bits - k));
  endfunction

endpackage

// File: rtl/addr_delay_line.sv
// Fixed-depth shift-register delay; every tap clears on reset so no stale
// valid can emerge after a mid-stream reset.
module addr_delay_line #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/pix_proc_pipe.sv
// Two-stage per-pixel op pipe (pass / mask / threshold / highlight) with a
// delayed write address and a saturating per-frame threshold-hit counter.
module pix_proc_pipe
  import pix_pkg::*;
#(
  parameter int PIX_PER_WORD = 2,
  parameter int CH_BITS      = PIX_CH_BITS_DEF,
  parameter int ADDR_W       = 19,
  parameter int ADDR_SKEW    = 0,
  parameter int CNT_W        = 20,
  localparam int PIX_W       = 3 * CH_BITS,
  localparam int WORD_W      = PIX_PER_WORD * PIX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [1:0]         mode,
  input  logic [2:0]         keep_r,
  input  logic [2:0]         keep_g,
  input  logic [2:0]         keep_b,
  input  logic [CH_BITS-1:0] thr_r,
  input  logic [CH_BITS-1:0] thr_g,
  input  logic [CH_BITS-1:0] thr_b,
  input  logic               frame_start,
  output logic               out_valid,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_addr_valid,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   hit_count_last
);

  localparam int HIT_W = $clog2(PIX_PER_WORD + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [CH_BITS-1:0]      mask_r, mask_g, mask_b;
  logic [WORD_W-1:0]       masked_word, proc_word;
  logic [PIX_PER_WORD-1:0] hit_vec;

  logic                    s1_valid;
  logic [WORD_W-1:0]       s1_raw, s1_masked;
  logic [PIX_PER_WORD-1:0] s1_hit;
  pix_mode_e               s1_mode;
  logic [HIT_W-1:0]        hit_sum, s2_hits;
  logic [SUM_W-1:0]        cnt_sum;
  logic [CNT_W-1:0]        cnt_next;

  assign mask_r = CH_BITS'(keep_mask(keep_r, CH_BITS));
  assign mask_g = CH_BITS'(keep_mask(keep_g, CH_BITS));
  assign mask_b = CH_BITS'(keep_mask(keep_b, CH_BITS));

  for (genvar p = 0; p < PIX_PER_WORD; p++) begin : g_pix
    localparam int HI = WORD_W - 1 - p * PIX_W;
    pix_max_t           raw_ext;
    logic [CH_BITS-1:0] r, g, b;
    logic [PIX_W-1:0]   proc_pix;

    assign raw_ext = pix_max_t'(in_data[HI -: PIX_W]);
    assign r = CH_BITS'(chan_get(raw_ext, CH_BITS, 0));
    assign g = CH_BITS'(chan_get(raw_ext, CH_BITS, 1));
    assign b = CH_BITS'(chan_get(raw_ext, CH_BITS, 2));

    assign masked_word[HI -: PIX_W] = PIX_W'(pix_pack(pix_ch_t'(r & mask_r),
                                                      pix_ch_t'(g & mask_g),
                                                      pix_ch_t'(b & mask_b), CH_BITS));
    // threshold compares raw channels, not masked ones
    assign hit_vec[p] = (r >= thr_r) && (g >= thr_g) && (b >= thr_b);

    always_comb begin
      proc_pix = s1_raw[HI -: PIX_W];
      unique case (s1_mode)
        PIX_MODE_PASS:   proc_pix = s1_raw[HI -: PIX_W];
        PIX_MODE_MASK:   proc_pix = s1_masked[HI -: PIX_W];
        PIX_MODE_THRESH: proc_pix = s1_hit[p] ? '1 : '0;
        PIX_MODE_HILITE: proc_pix = s1_hit[p] ? s1_masked[HI -: PIX_W] : '0;
        default:         proc_pix = s1_raw[HI -: PIX_W];
      endcase
    end

    assign proc_word[HI -: PIX_W] = proc_pix;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_raw    <= '0;
      s1_masked <= '0;
      s1_hit    <= '0;
      s1_mode   <= PIX_MODE_PASS;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_raw    <= in_data;
        s1_masked <= masked_word;
        s1_hit    <= hit_vec;
        s1_mode   <= pix_mode_e'(mode);
      end
    end
  end

  always_comb begin
    hit_sum = '0;
    for (int p = 0; p < PIX_PER_WORD; p++) hit_sum = hit_sum + HIT_W'(s1_hit[p]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      s2_hits   <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= proc_word;
        s2_hits  <= hit_sum;
      end
    end
  end

  // Counter credits the word in the cycle it is on out_valid; frame_start
  // restarts the count from that word's hits.
  always_comb begin
    cnt_sum  = (frame_start ? '0 : {1'b0, hit_count}) + (out_valid ? SUM_W'(s2_hits) : '0);
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count      <= '0;
      hit_count_last <= '0;
    end else begin
      hit_count <= cnt_next;
      if (frame_start) hit_count_last <= hit_count;
    end
  end

  addr_delay_line #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (2 + ADDR_SKEW)
  ) u_addr_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({in_valid, in_addr}),
    .dout  ({out_addr_valid, out_addr})
  );

endmodule

// File: tb/tb_pix_proc_pipe.sv
// Directed bench for pix_proc_pipe: default, 150-cycle address skew and 4-bit
// counter instances share one stimulus stream.
module tb_pix_proc_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [35:0] in_data;
  logic [18:0] in_addr;
  logic [1:0]  mode;
  logic [2:0]  keep_r, keep_g, keep_b;
  logic [5:0]  thr_r, thr_g, thr_b;
  logic        frame_start;

  logic        d_ov, d_oav, s_ov, s_oav, c_ov, c_oav;
  logic [35:0] d_od, s_od, c_od;
  logic [18:0] d_oa, s_oa, c_oa;
  logic [19:0] d_hc, d_hl, s_hc, s_hl;
  logic [3:0]  c_hc, c_hl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pix_proc_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
    .mode(mode), .keep_r(keep_r), .keep_g(keep_g), .keep_b(keep_b),
    .thr_r(thr_r), .thr_g(thr_g), .thr_b(thr_b), .frame_start(frame_start),
    .out_valid(d_ov), .out_data(d_od), .out_addr_valid(d_oav), .out_addr(d_oa),
    .hit_count(d_hc), .hit_count_last(d_hl));

  pix_proc_pipe #(.ADDR_SKEW(150)) dut_skew (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
    .mode(mode), .keep_r(keep_r), .keep_g(keep_g), .keep_b(keep_b),
    .thr_r(thr_r), .thr_g(thr_g), .thr_b(thr_b), .frame_start(frame_start),
    .out_valid(s_ov), .out_data(s_od), .out_addr_valid(s_oav), .out_addr(s_oa),
    .hit_count(s_hc), .hit_count_last(s_hl));

  pix_proc_pipe #(.CNT_W(4)) dut_cnt (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
    .mode(mode), .keep_r(keep_r), .keep_g(keep_g), .keep_b(keep_b),
    .thr_r(thr_r), .thr_g(thr_g), .thr_b(thr_b), .frame_start(frame_start),
    .out_valid(c_ov), .out_data(c_od), .out_addr_valid(c_oav), .out_addr(c_oa),
    .hit_count(c_hc), .hit_count_last(c_hl));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [35:0] d, input logic [18:0] a);
    in_valid = 1'b1;
    in_data  = d;
    in_addr  = a;
    tick();
  endtask

  logic [35:0] w_ones, w_mask, w_clamp, w_thr_in, w_thr_out, w_hl_in, w_hl_out, w_pass;
  logic        seen;

  initial begin
    w_ones    = 36'hF_FFFF_FFFF;
    w_pass    = 36'h3F_F00_0AB;
    w_mask    = {6'h30, 6'h38, 6'h30, 6'h30, 6'h38, 6'h30};
    w_clamp   = {6'h00, 6'h3F, 6'h3F, 6'h00, 6'h3F, 6'h3F};
    w_thr_in  = {6'd40, 6'd40, 6'd40, 6'd40, 6'd10, 6'd40};
    w_thr_out = {18'h3FFFF, 18'h0};
    w_hl_in   = {6'd40, 6'd41, 6'd63, 6'd39, 6'd63, 6'd63};
    w_hl_out  = {6'd40, 6'd40, 6'd56, 18'h0};

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0; mode = 2'd0;
    keep_r = 3'd6; keep_g = 3'd6; keep_b = 3'd6;
    thr_r = 6'd0; thr_g = 6'd0; thr_b = 6'd0; frame_start = 1'b0;
    #2;
    chk("rst_ov", d_ov, 0);
    chk("rst_od", d_od, 0);
    chk("rst_oav", d_oav, 0);
    chk("rst_oa", d_oa, 0);
    chk("rst_hc", d_hc, 0);
    chk("rst_hl", d_hl, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // PASS, thr=0 so both pixels hit
    send(w_pass, 19'd5);
    in_valid = 1'b0;
    chk("pass_n1_ov", d_ov, 0);
    tick();
    chk("pass_ov", d_ov, 1);
    chk("pass_od", d_od, w_pass);
    chk("pass_oav", d_oav, 1);
    chk("pass_oa", d_oa, 5);
    chk("skew_ov", s_ov, 1);
    chk("skew_oav_early", s_oav, 0);
    tick();
    chk("bubble_ov", d_ov, 0);
    chk("bubble_hold", d_od, w_pass);
    chk("pass_hc", d_hc, 2);

    // back-to-back beats, op changes per beat
    mode = 2'd1; keep_r = 3'd2; keep_g = 3'd3; keep_b = 3'd2;
    send(w_ones, 19'd10);
    keep_r = 3'd0; keep_g = 3'd7; keep_b = 3'd6;
    send(w_ones, 19'd11);
    chk("mask_ov", d_ov, 1);
    chk("mask_od", d_od, w_mask);
    chk("mask_oa", d_oa, 10);
    mode = 2'd2; thr_r = 6'd32; thr_g = 6'd32; thr_b = 6'd32;
    send(w_thr_in, 19'd12);
    chk("clamp_od", d_od, w_clamp);
    chk("clamp_oa", d_oa, 11);
    mode = 2'd3; keep_r = 3'd3; keep_g = 3'd3; keep_b = 3'd3;
    thr_r = 6'd40; thr_g = 6'd40; thr_b = 6'd40;
    send(w_hl_in, 19'd13);
    chk("thr_od", d_od, w_thr_out);
    chk("thr_oa", d_oa, 12);
    in_valid = 1'b0; mode = 2'd0;
    tick();
    chk("hl_ov", d_ov, 1);
    chk("hl_od", d_od, w_hl_out);
    tick();
    chk("hl_after_ov", d_ov, 0);
    chk("hc_mix", d_hc, 8);

    // address skew 150: out_addr at N+152 only
    repeat (160) tick();
    thr_r = 6'd63; thr_g = 6'd63; thr_b = 6'd63;
    send(36'h0, 19'd7);
    in_valid = 1'b0;
    tick();
    chk("skew_data_ov", s_ov, 1);
    chk("skew_n2_oav", s_oav, 0);
    repeat (149) tick();
    chk("skew_n151_oav", s_oav, 0);
    tick();
    chk("skew_n152_oav", s_oav, 1);
    chk("skew_n152_oa", s_oa, 7);
    tick();
    chk("skew_n153_oav", s_oav, 0);

    // counter saturation on the 4-bit instance
    thr_r = 6'd0; thr_g = 6'd0; thr_b = 6'd0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fs0_d_hl", d_hl, 8);
    chk("fs0_c_hl", c_hl, 8);
    chk("fs0_c_hc", c_hc, 0);
    for (int i = 0; i < 10; i++) send(w_ones, 19'(i));
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_c_hc", c_hc, 15);
    chk("nosat_d_hc", d_hc, 20);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fs1_c_hl", c_hl, 15);
    chk("fs1_c_hc", c_hc, 0);
    chk("fs1_d_hl", d_hl, 20);

    // frame_start coincident with an out_valid word
    send(w_ones, 19'd30);
    in_valid = 1'b0;
    tick();
    chk("coin_ov", c_ov, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("coin_c_hc", c_hc, 2);
    chk("coin_c_hl", c_hl, 0);

    // async reset with two beats in flight
    send(w_pass, 19'd20);
    in_valid = 1'b1; in_data = w_ones; in_addr = 19'd21;
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_ov", d_ov, 0);
    chk("mrst_od", d_od, 0);
    chk("mrst_hc", d_hc, 0);
    chk("mrst_c_hc", c_hc, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | d_ov | d_oav | s_ov;
    end
    chk("mrst_no_valid", seen, 0);
    send(w_pass, 19'd44);
    in_valid = 1'b0;
    tick();
    chk("recover_ov", d_ov, 1);
    chk("recover_oa", d_oa, 44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
